// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: multi-cycle ALU codes, forward-select values, md FSM states.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package pipe_pkg;

  // EXE ALU operation codes that occupy EXE for more than one cycle
  localparam logic [5:0] ALU_MULT  = 6'h18;
  localparam logic [5:0] ALU_MULTU = 6'h19;
  localparam logic [5:0] ALU_DIV   = 6'h1A;
  localparam logic [5:0] ALU_DIVU  = 6'h1B;

  // Operand forward select encoding; 2'd3 is never driven
  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // Multiply/divide occupancy FSM
  typedef logic [0:0] md_state_t;
  localparam md_state_t ST_IDLE    = 1'b0;
  localparam md_state_t ST_MD_BUSY = 1'b1;

  function automatic logic is_md_op(input logic [5:0] op);
    return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [5:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Operand forward select for one EXE source register (MEM > WB > register file).
// Latency: purely combinational, zero cycles.
// Backpressure: none; sources are held stable by the pipeline during FREEZE.
// Ports: i_src (EXE source), i_mem_wr/i_mem_dst, i_wb_wr/i_wb_dst, o_sel (2-bit select).
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] i_src,
  input  logic       i_mem_wr,
  input  logic [4:0] i_mem_dst,
  input  logic       i_wb_wr,
  input  logic [4:0] i_wb_dst,
  output logic [1:0] o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  // A zero destination never matches, so r0 always reads the register file
  assign w_mem_hit = i_mem_wr && (i_mem_dst != 5'd0) && (i_mem_dst == i_src);
  assign w_wb_hit  = i_wb_wr  && (i_wb_dst  != 5'd0) && (i_wb_dst  == i_src);

  always_comb begin
    o_sel = FWD_RF;
    if (w_mem_hit)     o_sel = FWD_MEM;
    else if (w_wb_hit) o_sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: operand forwarding, load-use stall, multi-cycle mul/div freeze.
// Latency: all outputs combinational from inputs and the md FSM state.
// Backpressure: FREEZE holds every pipeline register and overrides the load-use stall/bubble.
// Ports: CLK/RESET (async active-low); ID operands (id_*); EXE sources, op, dest, load flag;
//   MEM/WB destinations; outputs fwdA_sel/fwdB_sel, FREEZE, stall_front, bubble_EXE, md_busy.
// Build option: define HAZ_MULDIV_EN to enable the multi-cycle mul/div freeze FSM; otherwise
//   FREEZE and md_busy are tied low and mul/div are treated as single-cycle.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic [4:0] readRegisterA1,
  input  logic [4:0] readRegisterB1,
  input  logic [5:0] ALU_control1,
  input  logic [4:0] writeRegister1,
  input  logic       do_writeback1_ID,
  input  logic       MemRead1,
  input  logic [4:0] writeRegister1_PR,
  input  logic       do_writeback1_PR,
  input  logic [4:0] writeRegister1_WB,
  input  logic       do_writeback1_WB,
  output logic [1:0] fwdA_sel,
  output logic [1:0] fwdB_sel,
  output logic       FREEZE,
  output logic       stall_front,
  output logic       bubble_EXE,
  output logic       md_busy
);

  logic w_load_use;
  logic w_freeze;

  fwd_unit u_fwd_a (
    .i_src     (readRegisterA1),
    .i_mem_wr  (do_writeback1_PR),
    .i_mem_dst (writeRegister1_PR),
    .i_wb_wr   (do_writeback1_WB),
    .i_wb_dst  (writeRegister1_WB),
    .o_sel     (fwdA_sel)
  );

  fwd_unit u_fwd_b (
    .i_src     (readRegisterB1),
    .i_mem_wr  (do_writeback1_PR),
    .i_mem_dst (writeRegister1_PR),
    .i_wb_wr   (do_writeback1_WB),
    .i_wb_dst  (writeRegister1_WB),
    .o_sel     (fwdB_sel)
  );

  // Load in EXE whose result the ID instruction needs next cycle
  assign w_load_use = id_valid && MemRead1 && do_writeback1_ID && (writeRegister1 != 5'd0) &&
                      ((id_rs == writeRegister1) || (id_uses_rt && (id_rt == writeRegister1)));

`ifdef HAZ_MULDIV_EN

  localparam logic [5:0] MUL_CNT_INIT = 6'(MUL_LAT - 2);
  localparam logic [5:0] DIV_CNT_INIT = 6'(DIV_LAT - 2);

  md_state_t  r_state;
  logic [5:0] r_md_cnt;
  logic       w_md_op;

  assign w_md_op = is_md_op(ALU_control1);

  // The first freeze cycle is raised from IDLE on the op itself, so the counter only has
  // to cover LAT-2 further freeze cycles plus one final unfrozen cycle in MD_BUSY.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= ST_IDLE;
      r_md_cnt <= 6'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_md_op) begin
            r_state  <= ST_MD_BUSY;
            r_md_cnt <= is_div_op(ALU_control1) ? DIV_CNT_INIT : MUL_CNT_INIT;
          end
        end
        default: begin
          if (r_md_cnt != 6'd0) begin
            r_md_cnt <= r_md_cnt - 6'd1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // RESET gates the IDLE-start term too, so a md op still sitting in EXE while reset is
  // asserted cannot raise FREEZE against a pipeline that is being cleared.
  assign w_freeze = RESET && (((r_state == ST_IDLE) && w_md_op) ||
                              ((r_state == ST_MD_BUSY) && (r_md_cnt != 6'd0)));
  assign md_busy  = (r_state == ST_MD_BUSY);

`else

  logic w_unused_md;

  assign w_unused_md = ^{CLK, RESET, ALU_control1, 6'(MUL_LAT), 6'(DIV_LAT)};
  assign w_freeze    = 1'b0;
  assign md_busy     = 1'b0;

`endif

  assign FREEZE = w_freeze;

  // Freeze wins: the load-use check is repeated once the pipeline moves again
  assign stall_front = w_load_use && !w_freeze;
  assign bubble_EXE  = w_load_use && !w_freeze;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  import pipe_pkg::*;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;
`ifdef HAZ_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif
  localparam logic [5:0] ALU_ADD = 6'h20;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       id_valid;
  logic [4:0] id_rs, id_rt;
  logic       id_uses_rt;
  logic [4:0] readRegisterA1, readRegisterB1;
  logic [5:0] ALU_control1;
  logic [4:0] writeRegister1;
  logic       do_writeback1_ID, MemRead1;
  logic [4:0] writeRegister1_PR;
  logic       do_writeback1_PR;
  logic [4:0] writeRegister1_WB;
  logic       do_writeback1_WB;
  logic [1:0] fwdA_sel, fwdB_sel;
  logic       FREEZE, stall_front, bubble_EXE, md_busy;

  hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .CLK(CLK), .RESET(RESET),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .readRegisterA1(readRegisterA1), .readRegisterB1(readRegisterB1),
    .ALU_control1(ALU_control1), .writeRegister1(writeRegister1),
    .do_writeback1_ID(do_writeback1_ID), .MemRead1(MemRead1),
    .writeRegister1_PR(writeRegister1_PR), .do_writeback1_PR(do_writeback1_PR),
    .writeRegister1_WB(writeRegister1_WB), .do_writeback1_WB(do_writeback1_WB),
    .fwdA_sel(fwdA_sel), .fwdB_sel(fwdB_sel), .FREEZE(FREEZE),
    .stall_front(stall_front), .bubble_EXE(bubble_EXE), .md_busy(md_busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  // Model: EXE cycles still owed to the md op in EXE (0 = no op in progress)
  int occ = 0;
  logic [1:0] s_fa, s_fb;
  logic       s_freeze, s_stall, s_bub, s_busy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (src == 5'd0) return 2'd0;
    if (do_writeback1_PR && writeRegister1_PR == src) return 2'd1;
    if (do_writeback1_WB && writeRegister1_WB == src) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic m_lu();
    return id_valid && MemRead1 && do_writeback1_ID && (writeRegister1 != 5'd0) &&
           (id_rs == writeRegister1 || (id_uses_rt && id_rt == writeRegister1));
  endfunction

  function automatic int m_lat(input logic [5:0] op);
    if (!MD_EN) return 0;
    if (op == ALU_MULT || op == ALU_MULTU) return MUL_LAT;
    if (op == ALU_DIV || op == ALU_DIVU) return DIV_LAT;
    return 0;
  endfunction

  // Called just after a falling edge with inputs applied; checks, then advances one cycle.
  task automatic step(input string tag);
    int oc;
    logic ef, ebusy, elu;
    #1;
    oc = occ;
    if (!RESET) oc = 0;
    else if (oc == 0 && m_lat(ALU_control1) != 0) oc = m_lat(ALU_control1);
    ef    = (oc > 1);
    ebusy = RESET && (occ > 0);
    elu   = m_lu();
    s_fa = fwdA_sel; s_fb = fwdB_sel; s_freeze = FREEZE;
    s_stall = stall_front; s_bub = bubble_EXE; s_busy = md_busy;
    check_eq({tag, ".fwdA"}, 32'(fwdA_sel), 32'(m_fwd(readRegisterA1)));
    check_eq({tag, ".fwdB"}, 32'(fwdB_sel), 32'(m_fwd(readRegisterB1)));
    check_eq({tag, ".freeze"}, 32'(FREEZE), 32'(ef));
    check_eq({tag, ".busy"}, 32'(md_busy), 32'(ebusy));
    check_eq({tag, ".stall"}, 32'(stall_front), 32'(elu && !ef));
    check_eq({tag, ".bubble"}, 32'(bubble_EXE), 32'(elu && !ef));
    @(posedge CLK);
    occ = (RESET && oc > 0) ? oc - 1 : 0;
    @(negedge CLK);
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    readRegisterA1 = 0; readRegisterB1 = 0; ALU_control1 = ALU_ADD;
    writeRegister1 = 0; do_writeback1_ID = 0; MemRead1 = 0;
    writeRegister1_PR = 0; do_writeback1_PR = 0;
    writeRegister1_WB = 0; do_writeback1_WB = 0;
  endtask

  initial begin
    int nfrz;
    logic [3:0] mult_frz;
    logic [3:0] mult_busy;
    mult_frz  = MD_EN ? 4'b0111 : 4'b0000;   // bit i = cycle i+1
    mult_busy = MD_EN ? 4'b1110 : 4'b0000;

    RESET = 1'b0;
    clear_inputs();
    ALU_control1 = ALU_DIV;
    @(negedge CLK);
    step("rst");
    check_eq("rst_freeze", 32'(s_freeze), 32'd0);
    check_eq("rst_busy", 32'(s_busy), 32'd0);
    RESET = 1'b1;
    ALU_control1 = ALU_ADD;
    step("idle");

    // Forwarding priority
    writeRegister1_PR = 5; do_writeback1_PR = 1;
    writeRegister1_WB = 5; do_writeback1_WB = 1;
    readRegisterA1 = 5;
    step("pri_mem");
    check_eq("pri_mem_sel", 32'(s_fa), 32'd1);
    do_writeback1_PR = 0;
    step("pri_wb");
    check_eq("pri_wb_sel", 32'(s_fa), 32'd2);

    // Register 0 never forwarded
    writeRegister1_PR = 0; do_writeback1_PR = 1;
    writeRegister1_WB = 0; do_writeback1_WB = 1;
    readRegisterA1 = 0; readRegisterB1 = 0;
    step("r0");
    check_eq("r0_a", 32'(s_fa), 32'd0);
    check_eq("r0_b", 32'(s_fb), 32'd0);
    clear_inputs();

    // Load-use
    MemRead1 = 1; do_writeback1_ID = 1; writeRegister1 = 8;
    id_valid = 1; id_rs = 8;
    step("lu_rs");
    check_eq("lu_rs_stall", 32'(s_stall), 32'd1);
    check_eq("lu_rs_bubble", 32'(s_bub), 32'd1);
    id_rs = 3; id_rt = 8; id_uses_rt = 0;
    step("lu_nort");
    check_eq("lu_nort_stall", 32'(s_stall), 32'd0);
    id_uses_rt = 1;
    step("lu_rt");
    check_eq("lu_rt_stall", 32'(s_stall), 32'd1);
    clear_inputs();
    step("lu_gone");

    // Single MULT
    ALU_control1 = ALU_MULT;
    for (int i = 0; i < 4; i++) begin
      step("mult");
      check_eq($sformatf("mult_frz_c%0d", i + 1), 32'(s_freeze), 32'(mult_frz[i]));
      check_eq($sformatf("mult_busy_c%0d", i + 1), 32'(s_busy), 32'(mult_busy[i]));
    end
    ALU_control1 = ALU_ADD;
    step("mult_done");
    check_eq("mult_done_busy", 32'(s_busy), 32'd0);

    // MULT while load-use pending: freeze wins, load-use reappears after
    ALU_control1 = ALU_MULT;
    MemRead1 = 1; do_writeback1_ID = 1; writeRegister1 = 9; id_valid = 1; id_rs = 9;
    for (int i = 0; i < 4; i++) begin
      step("mult_lu");
      check_eq($sformatf("mult_lu_stall_c%0d", i + 1), 32'(s_stall), 32'(!mult_frz[i]));
    end
    clear_inputs();
    step("mult_lu_end");

    // Back-to-back MULT, MULT
    ALU_control1 = ALU_MULT;
    for (int i = 0; i < 8; i++) begin
      step("b2b");
      check_eq($sformatf("b2b_frz_c%0d", i + 1), 32'(s_freeze), 32'(mult_frz[i % 4]));
    end
    ALU_control1 = ALU_ADD;
    step("b2b_end");

    // DIV with reset at freeze cycle 10, then a fresh DIV
    ALU_control1 = ALU_DIV;
    for (int i = 0; i < 9; i++) step("div_pre");
    RESET = 1'b0;
    step("div_rst");
    check_eq("div_rst_freeze", 32'(s_freeze), 32'd0);
    check_eq("div_rst_busy", 32'(s_busy), 32'd0);
    RESET = 1'b1;
    nfrz = 0;
    for (int i = 0; i < DIV_LAT + 4; i++) begin
      step("div2");
      if (!s_freeze) break;
      nfrz++;
    end
    check_eq("div2_freeze_cycles", 32'(nfrz), MD_EN ? 32'(DIV_LAT - 1) : 32'd0);
    ALU_control1 = ALU_ADD;
    step("div2_end");

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      RESET = ($urandom_range(0, 199) != 0);
      id_valid = 1'($urandom);
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom);
      readRegisterA1 = 5'($urandom_range(0, 3)); readRegisterB1 = 5'($urandom_range(0, 3));
      writeRegister1 = 5'($urandom_range(0, 3));
      do_writeback1_ID = 1'($urandom); MemRead1 = 1'($urandom);
      writeRegister1_PR = 5'($urandom_range(0, 3)); do_writeback1_PR = 1'($urandom);
      writeRegister1_WB = 5'($urandom_range(0, 3)); do_writeback1_WB = 1'($urandom);
      if (occ == 0) begin
        case ($urandom_range(0, 19))
          0: ALU_control1 = ALU_MULT;
          1: ALU_control1 = ALU_MULTU;
          2: ALU_control1 = ALU_DIVU;
          3: ALU_control1 = ALU_DIV;
          default: ALU_control1 = 6'($urandom_range(0, 23));
        endcase
      end
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
